// File: rtl/arrow_pkg.sv
// Shared types and constants for the arrow-key position controller.
package arrow_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        COOLDOWN = 1'b1
    } arrow_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/pulse_stretch.sv
// Retriggerable pulse stretcher: a trig cycle holds out high for LENGTH cycles,
// and each new trig restarts the count.
module pulse_stretch #(
    parameter int LENGTH = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic out
);

    localparam int CW = $clog2(LENGTH + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;

    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (trig) begin
            cnt_d = CW'(LENGTH - 1);
            out_d = 1'b1;
        end else if (out_q) begin
            if (cnt_q == '0) begin
                out_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/arrow_position_ctrl.sv
// Turns left/right arrow indications into a saturating cursor position with
// a post-move cooldown and a stretched flag for moves refused at a limit.
//
// state    | meaning
// IDLE     | waiting for a single arrow edge
// COOLDOWN | move accepted; all arrow edges dropped until counter expires
module arrow_position_ctrl
    import arrow_pkg::*;
#(
    parameter int POS_WIDTH       = 4,
    parameter int POS_MAX         = 15,
    parameter int POS_INIT        = 8,
    parameter int COOLDOWN_CYCLES = 2_500_000,
    parameter int FLASH_CYCLES    = 10_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 left_arrow,
    input  logic                 right_arrow,
    output logic [POS_WIDTH-1:0] position,
    output logic [POS_MAX:0]     pos_onehot,
    output logic                 at_left_limit,
    output logic                 at_right_limit,
    output logic                 move_valid,
    output logic                 move_dir,
    output logic                 limit_led
);

    localparam int             CW          = $clog2(COOLDOWN_CYCLES + 1);
    localparam logic [POS_MAX:0] ONEHOT_LSB = {{POS_MAX{1'b0}}, 1'b1};
    localparam logic [POS_MAX:0] ONEHOT_INIT = ONEHOT_LSB << POS_INIT;

    arrow_state_t         state_q, state_d;
    logic [CW-1:0]        cool_q, cool_d;
    logic [POS_WIDTH-1:0] pos_q, pos_d;
    logic [POS_MAX:0]     onehot_q, onehot_d;
    logic                 at_left_q, at_left_d;
    logic                 at_right_q, at_right_d;
    logic                 mv_q, mv_d;
    logic                 dir_q, dir_d;
    logic                 left_q, right_q;
    logic                 left_ev, right_ev;
    logic                 limit_trig;

    always_comb begin
        left_ev    = left_arrow & ~left_q;
        right_ev   = right_arrow & ~right_q;
        state_d    = state_q;
        cool_d     = cool_q;
        pos_d      = pos_q;
        dir_d      = dir_q;
        mv_d       = 1'b0;
        limit_trig = 1'b0;
        case (state_q)
            IDLE: begin
                // Coincident left+right edges cancel out entirely.
                if (left_ev ^ right_ev) begin
                    if ((right_ev && at_right_q) || (left_ev && at_left_q)) begin
                        limit_trig = 1'b1;
                    end else begin
                        pos_d   = right_ev ? pos_q + POS_WIDTH'(1) : pos_q - POS_WIDTH'(1);
                        dir_d   = right_ev ? DIR_RIGHT : DIR_LEFT;
                        mv_d    = 1'b1;
                        cool_d  = CW'(COOLDOWN_CYCLES - 1);
                        state_d = COOLDOWN;
                    end
                end
            end
            COOLDOWN: begin
                if (cool_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cool_d = cool_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        onehot_d   = ONEHOT_LSB << pos_d;
        at_left_d  = (pos_d == '0);
        at_right_d = (pos_d == POS_WIDTH'(POS_MAX));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cool_q     <= '0;
            pos_q      <= POS_WIDTH'(POS_INIT);
            onehot_q   <= ONEHOT_INIT;
            at_left_q  <= (POS_INIT == 0);
            at_right_q <= (POS_INIT == POS_MAX);
            mv_q       <= 1'b0;
            dir_q      <= DIR_LEFT;
            left_q     <= 1'b1;
            right_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cool_q     <= cool_d;
            pos_q      <= pos_d;
            onehot_q   <= onehot_d;
            at_left_q  <= at_left_d;
            at_right_q <= at_right_d;
            mv_q       <= mv_d;
            dir_q      <= dir_d;
            left_q     <= left_arrow;
            right_q    <= right_arrow;
        end
    end

    pulse_stretch #(
        .LENGTH(FLASH_CYCLES)
    ) u_limit_flash (
        .clk (clk),
        .rst (rst),
        .trig(limit_trig),
        .out (limit_led)
    );

    assign position       = pos_q;
    assign pos_onehot     = onehot_q;
    assign at_left_limit  = at_left_q;
    assign at_right_limit = at_right_q;
    assign move_valid     = mv_q;
    assign move_dir       = dir_q;

endmodule
